// File: rtl/vtree_feed_sched.sv
// Refill scheduler for a virtual merge sorter tree: issues round-robin refill
// requests for empty ways and forwards returning blocks into the tree.
module vtree_feed_sched #(
    parameter int W_LOG   = 10,
    parameter int P_LOG   = 3,
    parameter int DATW    = 64,
    parameter int MAX_OUT = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       ENABLE,
    input  logic [(1<<W_LOG)-1:0]      EMP,
    output logic                       REQ,
    output logic [W_LOG-1:0]           REQ_IDX,
    input  logic                       REQ_RDY,
    input  logic [(DATW<<P_LOG)-1:0]   RSP_DAT,
    input  logic                       RSP_EN,
    input  logic [W_LOG-1:0]           RSP_IDX,
    output logic [(DATW<<P_LOG)-1:0]   DOT,
    output logic                       DOTEN,
    output logic [W_LOG-1:0]           DOT_IDX,
    output logic                       ERR
);

    localparam int N = 1 << W_LOG;

    logic [N-1:0]     pending;
    logic [N-1:0]     cand;
    logic [N-1:0]     ptr_mask;
    logic [N-1:0]     masked;
    logic [3:0]       cnt;
    logic [W_LOG-1:0] ptr;
    logic [W_LOG-1:0] grant;
    logic [W_LOG-1:0] g_hi;
    logic [W_LOG-1:0] g_lo;
    logic             hit_hi;
    logic             issue;
    logic             rsp_ok;
    logic             grd_v;
    logic [W_LOG-1:0] grd_idx;

    // Scanning from the top down leaves the lowest set index in g_lo / g_hi.
    always_comb begin
        cand     = EMP & ~pending;
        ptr_mask = {N{1'b1}} << ptr;
        masked   = cand & ptr_mask;
        g_hi     = '0;
        g_lo     = '0;
        hit_hi   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cand[N-1-i])
                g_lo = W_LOG'(N - 1 - i);
            if (masked[N-1-i]) begin
                g_hi   = W_LOG'(N - 1 - i);
                hit_hi = 1'b1;
            end
        end
        grant  = hit_hi ? g_hi : g_lo;
        issue  = ENABLE && (|cand) && (cnt < 4'(MAX_OUT)) && (!REQ || REQ_RDY);
        rsp_ok = RSP_EN && pending[RSP_IDX];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            REQ     <= 1'b0;
            REQ_IDX <= '0;
            DOT     <= '0;
            DOTEN   <= 1'b0;
            DOT_IDX <= '0;
            ERR     <= 1'b0;
            pending <= '0;
            cnt     <= '0;
            ptr     <= '0;
            grd_v   <= 1'b0;
            grd_idx <= '0;
        end else begin
            if (issue) begin
                REQ     <= 1'b1;
                REQ_IDX <= grant;
                ptr     <= grant + W_LOG'(1);
            end else if (REQ && REQ_RDY) begin
                REQ <= 1'b0;
            end

            if (issue && !rsp_ok)
                cnt <= cnt + 4'd1;
            else if (!issue && rsp_ok && cnt != '0)
                cnt <= cnt - 4'd1;

            DOTEN <= rsp_ok;
            if (rsp_ok) begin
                DOT     <= RSP_DAT;
                DOT_IDX <= RSP_IDX;
            end
            if (RSP_EN && !pending[RSP_IDX])
                ERR <= 1'b1;

            // Pending stays set one extra cycle past DOTEN so the tree's EMP can settle.
            grd_v   <= DOTEN;
            grd_idx <= DOT_IDX;
            if (grd_v)
                pending[grd_idx] <= 1'b0;
            if (issue)
                pending[grant] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vtree_feed_sched.sv
// Directed self-checking bench for vtree_feed_sched with default parameters.
module tb_vtree_feed_sched;

    localparam int WL = 10;
    localparam int N  = 1 << WL;
    localparam int BW = 64 << 3;

    logic            CLK = 1'b0;
    logic            RST;
    logic            ENABLE;
    logic [N-1:0]    EMP;
    logic            REQ;
    logic [WL-1:0]   REQ_IDX;
    logic            REQ_RDY;
    logic [BW-1:0]   RSP_DAT;
    logic            RSP_EN;
    logic [WL-1:0]   RSP_IDX;
    logic [BW-1:0]   DOT;
    logic            DOTEN;
    logic [WL-1:0]   DOT_IDX;
    logic            ERR;

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] d0;

    vtree_feed_sched #(
        .W_LOG   (WL),
        .P_LOG   (3),
        .DATW    (64),
        .MAX_OUT (4)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .ENABLE  (ENABLE),
        .EMP     (EMP),
        .REQ     (REQ),
        .REQ_IDX (REQ_IDX),
        .REQ_RDY (REQ_RDY),
        .RSP_DAT (RSP_DAT),
        .RSP_EN  (RSP_EN),
        .RSP_IDX (RSP_IDX),
        .DOT     (DOT),
        .DOTEN   (DOTEN),
        .DOT_IDX (DOT_IDX),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] blk(input int k);
        return {16{32'h1000_0000 + 32'(k)}};
    endfunction

    initial begin
        RST = 1'b1; ENABLE = 1'b0; EMP = '0; REQ_RDY = 1'b0;
        RSP_DAT = '0; RSP_EN = 1'b0; RSP_IDX = '0;
        d0 = {8{64'hDEAD_BEEF_0123_4567}};

        // reset state
        step();
        check_val("rst_req", REQ, 0);
        check_val("rst_req_idx", REQ_IDX, 0);
        check_val("rst_doten", DOTEN, 0);
        check_val("rst_dot", DOT, 0);
        check_val("rst_dot_idx", DOT_IDX, 0);
        check_val("rst_err", ERR, 0);

        // all ways empty: grants 0..3 then stall at MAX_OUT
        RST = 1'b0; ENABLE = 1'b1; EMP = '1; REQ_RDY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("seq_req", REQ, 1);
            check_val("seq_idx", REQ_IDX, 1024'(i));
        end
        step();
        check_val("full_req_low", REQ, 0);
        check_val("full_cnt", dut.cnt, 4);
        step();
        check_val("full_req_stays_low", REQ, 0);

        // response at full count: forwarded, issue resumes one cycle later
        RSP_EN = 1'b1; RSP_IDX = 0; RSP_DAT = d0;
        step();
        check_val("rsp0_doten", DOTEN, 1);
        check_val("rsp0_dot_idx", DOT_IDX, 0);
        check_val("rsp0_dot", DOT, d0);
        check_val("rsp0_no_issue", REQ, 0);
        check_val("rsp0_cnt", dut.cnt, 3);
        RSP_EN = 1'b0;
        step();
        check_val("resume_req", REQ, 1);
        check_val("resume_idx", REQ_IDX, 4);
        check_val("doten_drop", DOTEN, 0);
        check_val("dot_hold", DOT, d0);
        ENABLE = 1'b0; EMP = '0;
        step();
        check_val("resume_req_fall", REQ, 0);

        for (int k = 1; k <= 4; k++) begin
            RSP_EN = 1'b1; RSP_IDX = WL'(k); RSP_DAT = blk(k);
            step();
            check_val("drain_doten", DOTEN, 1);
            check_val("drain_dot_idx", DOT_IDX, 1024'(k));
            check_val("drain_dot", DOT, blk(k));
        end
        RSP_EN = 1'b0;
        repeat (3) step();
        check_val("drain_cnt", dut.cnt, 0);
        check_val("drain_pending", |dut.pending, 0);

        // round robin with ptr=3 over ways {5,2}
        RST = 1'b1;
        step();
        RST = 1'b0;
        EMP = '0; EMP[2] = 1'b1; ENABLE = 1'b1;
        step();
        check_val("rr_setup_idx", REQ_IDX, 2);
        ENABLE = 1'b0;
        step();
        check_val("rr_setup_fall", REQ, 0);
        RSP_EN = 1'b1; RSP_IDX = 2; RSP_DAT = blk(2);
        step();
        check_val("rr_setup_doten", DOTEN, 1);
        RSP_EN = 1'b0;
        step();
        check_val("guard2_still_pending", dut.pending[2], 1);
        step();
        check_val("guard2_cleared", dut.pending[2], 0);

        EMP[5] = 1'b1; ENABLE = 1'b1;
        step();
        check_val("rr_first", REQ_IDX, 5);
        step();
        check_val("rr_wrap_req", REQ, 1);
        check_val("rr_wrap", REQ_IDX, 2);
        ENABLE = 1'b0;
        step();
        check_val("rr_fall", REQ, 0);
        RSP_EN = 1'b1; RSP_IDX = 5; RSP_DAT = blk(5);
        step();
        check_val("rr_rsp5", DOT_IDX, 5);
        RSP_IDX = 2; RSP_DAT = blk(2);
        step();
        check_val("rr_rsp2", DOT_IDX, 2);
        check_val("rr_rsp2_doten", DOTEN, 1);
        RSP_EN = 1'b0;
        repeat (3) step();
        ENABLE = 1'b1;
        step();
        check_val("rr_again_first", REQ_IDX, 5);
        step();
        check_val("rr_again_second", REQ_IDX, 2);
        ENABLE = 1'b0;
        step();
        check_val("rr_again_fall", REQ, 0);

        // REQ_RDY stalled for 6 cycles
        EMP = '0; EMP[7] = 1'b1; EMP[8] = 1'b1; ENABLE = 1'b1; REQ_RDY = 1'b0;
        step();
        check_val("stall_req", REQ, 1);
        check_val("stall_idx", REQ_IDX, 7);
        for (int i = 0; i < 6; i++) begin
            step();
            check_val("stall_hold_req", REQ, 1);
            check_val("stall_hold_idx", REQ_IDX, 7);
        end
        check_val("stall_cnt", dut.cnt, 3);
        REQ_RDY = 1'b1; ENABLE = 1'b0;
        step();
        check_val("stall_accept_fall", REQ, 0);
        check_val("stall_one_accept", dut.cnt, 3);

        // simultaneous issue and response; guard timing for way 7
        ENABLE = 1'b1; RSP_EN = 1'b1; RSP_IDX = 7; RSP_DAT = BW'(1);
        step();
        check_val("sim_req", REQ, 1);
        check_val("sim_idx", REQ_IDX, 8);
        check_val("sim_doten", DOTEN, 1);
        check_val("sim_dot_idx", DOT_IDX, 7);
        check_val("sim_dot", DOT, 1);
        check_val("sim_cnt", dut.cnt, 3);
        ENABLE = 1'b0; RSP_EN = 1'b0;
        step();
        check_val("sim_doten_low", DOTEN, 0);
        check_val("sim_dot_hold", DOT, 1);
        check_val("guard7_still_pending", dut.pending[7], 1);
        step();
        check_val("guard7_cleared", dut.pending[7], 0);
        check_val("err_clear", ERR, 0);

        // unexpected response
        RSP_EN = 1'b1; RSP_IDX = 9; RSP_DAT = BW'(8'hAB);
        step();
        check_val("bad_rsp_doten", DOTEN, 0);
        check_val("bad_rsp_err", ERR, 1);
        check_val("bad_rsp_cnt", dut.cnt, 3);
        check_val("bad_rsp_dot", DOT, 1);
        RSP_EN = 1'b0;
        repeat (3) step();
        check_val("err_sticky", ERR, 1);

        // reset with requests outstanding
        EMP = '0; EMP[10] = 1'b1; ENABLE = 1'b1; REQ_RDY = 1'b0;
        RSP_EN = 1'b1; RSP_IDX = 8; RSP_DAT = blk(8);
        step();
        check_val("pre_rst_req", REQ, 1);
        check_val("pre_rst_idx", REQ_IDX, 10);
        check_val("pre_rst_cnt", dut.cnt, 3);
        RST = 1'b1; ENABLE = 1'b0; RSP_EN = 1'b0;
        step();
        check_val("mid_rst_req", REQ, 0);
        check_val("mid_rst_idx", REQ_IDX, 0);
        check_val("mid_rst_doten", DOTEN, 0);
        check_val("mid_rst_dot", DOT, 0);
        check_val("mid_rst_dot_idx", DOT_IDX, 0);
        check_val("mid_rst_err", ERR, 0);
        check_val("mid_rst_cnt", dut.cnt, 0);
        check_val("mid_rst_ptr", dut.ptr, 0);
        check_val("mid_rst_pending", |dut.pending, 0);
        RST = 1'b0; RSP_EN = 1'b1; RSP_IDX = 5; RSP_DAT = blk(5);
        step();
        check_val("stale_doten", DOTEN, 0);
        check_val("stale_err", ERR, 1);
        check_val("stale_cnt", dut.cnt, 0);
        RSP_EN = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
